fib_sub_arbiter: RTL and testbench

- Shares one sub_fibonacci subtractor instance among NREQ requesters, using round-robin arbitration.
- Orders the operands so the subtractor always receives minuend ≥ subtrahend, and reports the sign separately.
- Bypasses the subtractor for trivial cases (equal operands, zero subtrahend).
- Guards against a hung subtraction with a watchdog that resets the subtractor.

---
 rtl/fib_sub_arbiter.sv | 126 ++++++++++++
 tb/tb_fib_sub_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fib_sub_arbiter.sv
// fib_sub_arbiter: round-robin share of one Fibonacci subtractor among NREQ requesters
//   clk, rst(async, active-low)
//   req/a_flat/b_flat      : per-requester request level and operands (slot k at [k*W +: W])
//   gnt/rsp_valid          : one-hot grant and one-cycle response strobe
//   rsp_data/rsp_neg/rsp_err : |A-B|, sign (A<B), timeout flag; valid with rsp_valid
//   busy                   : not idle
//   sub_en/sub_i/sub_j/sub_rst_n/sub_out/sub_done : subtractor interface
module fib_sub_arbiter #(
   parameter int NREQ    = 4,
   parameter int W       = 32,
   parameter int TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] a_flat,
   input  logic [NREQ*W-1:0] b_flat,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [W-1:0]      rsp_data,
   output logic              rsp_neg,
   output logic              rsp_err,
   output logic              busy,
   output logic              sub_en,
   output logic [W-1:0]      sub_i,
   output logic [W-1:0]      sub_j,
   output logic              sub_rst_n,
   input  logic [W-1:0]      sub_out,
   input  logic              sub_done
);
   localparam int PW  = $clog2(NREQ);
   localparam int WDW = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, GRANT, ISSUE, WAIT, RESP, ABORT} state_t;
   state_t         state;
   logic [PW-1:0]  rr_ptr, k, win;
   logic [W-1:0]   a_r, b_r;
   logic [WDW-1:0] wd;
   logic           neg, ab;
   // descending scan so the last hit is the first high bit at or after rr_ptr
   always_comb begin
      win = '0;
      for (int i = NREQ - 1; i >= 0; i--)
         if (req[(int'(rr_ptr) + i) % NREQ]) win = PW'((int'(rr_ptr) + i) % NREQ);
   end
   assign busy      = state != IDLE;
   assign sub_rst_n = rst & (state != ABORT);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         k         <= '0;
         a_r       <= '0;
         b_r       <= '0;
         wd        <= '0;
         neg       <= 1'b0;
         ab        <= 1'b0;
         gnt       <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         rsp_neg   <= 1'b0;
         rsp_err   <= 1'b0;
         sub_en    <= 1'b0;
         sub_i     <= '0;
         sub_j     <= '0;
      end else begin
         sub_en    <= 1'b0;
         rsp_valid <= '0;
         case (state)
            IDLE: if (|req) begin
               gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << win;
               k     <= win;
               a_r   <= a_flat[int'(win)*W +: W];
               b_r   <= b_flat[int'(win)*W +: W];
               state <= GRANT;
            end
            GRANT: if (a_r == b_r || a_r == '0 || b_r == '0) begin
               // equal -> 0, B==0 -> A, A==0 -> B negated
               rsp_valid <= gnt;
               rsp_data  <= a_r == b_r ? '0 : b_r == '0 ? a_r : b_r;
               rsp_neg   <= a_r != b_r && b_r != '0;
               rsp_err   <= 1'b0;
               state     <= RESP;
            end else begin
               sub_i  <= a_r > b_r ? a_r : b_r;
               sub_j  <= a_r > b_r ? b_r : a_r;
               neg    <= a_r < b_r;
               sub_en <= 1'b1;
               wd     <= '0;
               state  <= ISSUE;
            end
            ISSUE: begin
               wd    <= '0;
               state <= WAIT;
            end
            WAIT: if (sub_done) begin
               rsp_valid <= gnt;
               rsp_data  <= sub_out;
               rsp_neg   <= neg;
               rsp_err   <= 1'b0;
               state     <= RESP;
            end else begin
               // abort after exactly TIMEOUT cycles spent in WAIT
               wd    <= wd + 1'b1;
               ab    <= 1'b0;
               state <= wd == WDW'(TIMEOUT - 1) ? ABORT : WAIT;
            end
            ABORT: begin
               ab <= 1'b1;
               if (ab) begin
                  rsp_valid <= gnt;
                  rsp_data  <= '0;
                  rsp_neg   <= neg;
                  rsp_err   <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               gnt    <= '0;
               rr_ptr <= k == PW'(NREQ - 1) ? '0 : k + 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fib_sub_arbiter.sv
// tb_fib_sub_arbiter: directed self-checking bench for fib_sub_arbiter
module tb_fib_sub_arbiter;
   localparam int NREQ = 4, W = 32, TIMEOUT = 1023;
   logic              clk = 1'b0, rst = 1'b0;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ*W-1:0] a_flat = '0, b_flat = '0;
   logic [NREQ-1:0]   gnt, rsp_valid;
   logic [W-1:0]      rsp_data, sub_i, sub_j, sub_out = '0;
   logic              rsp_neg, rsp_err, busy, sub_en, sub_rst_n, sub_done = 1'b0;
   int checks = 0, errors = 0;

   fib_sub_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req(req), .a_flat(a_flat), .b_flat(b_flat),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_neg(rsp_neg),
      .rsp_err(rsp_err), .busy(busy), .sub_en(sub_en), .sub_i(sub_i), .sub_j(sub_j),
      .sub_rst_n(sub_rst_n), .sub_out(sub_out), .sub_done(sub_done)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #2;
      checks++;
      if ({gnt, rsp_valid, rsp_data, rsp_neg, rsp_err, busy, sub_en, sub_i, sub_j, sub_rst_n} !== '0) begin
         errors++;
         $display("FAIL reset_outputs gnt=%b rsp_valid=%b data=%h busy=%b sub_en=%b sub_i=%h sub_j=%h sub_rst_n=%b expected all zero",
                  gnt, rsp_valid, rsp_data, busy, sub_en, sub_i, sub_j, sub_rst_n);
      end
      tick;
      rst = 1'b1;
      #1;
      checks++;
      if (sub_rst_n !== 1'b1) begin errors++; $display("FAIL reset_release sub_rst_n got %b expected 1", sub_rst_n); end
      tick;
   endtask

   task automatic test_round_robin;
      logic [NREQ-1:0] exp;
      a_flat = {4{32'h0000_0A52}};
      b_flat = {4{32'h0000_0A52}};
      req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         exp = 4'b0001 << (n % 4);
         tick;
         checks++;
         if (gnt !== exp || !$onehot(gnt)) begin errors++; $display("FAIL rr_grant[%0d] got %b expected %b", n, gnt, exp); end
         tick;
         checks++;
         if (rsp_valid !== exp || gnt !== exp || rsp_data !== '0) begin
            errors++; $display("FAIL rr_resp[%0d] rsp_valid=%b gnt=%b data=%h expected %b/%b/0", n, rsp_valid, gnt, rsp_data, exp, exp);
         end
         if (n == 4) req = '0;
         tick;
         checks++;
         if (gnt !== '0 || rsp_valid !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL rr_idle[%0d] gnt=%b rsp_valid=%b busy=%b expected 0/0/0", n, gnt, rsp_valid, busy);
         end
      end
   endtask

   task automatic test_normal(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] ei, input logic [W-1:0] ej, input logic eneg,
                              input logic [W-1:0] res, input int nwait);
      logic [NREQ-1:0] exp;
      exp = 4'b0001 << idx;
      a_flat[idx*W +: W] = a;
      b_flat[idx*W +: W] = b;
      req[idx] = 1'b1;
      tick;
      checks++;
      if (gnt !== exp || busy !== 1'b1) begin errors++; $display("FAIL norm_grant[%0d] gnt=%b busy=%b expected %b/1", idx, gnt, busy, exp); end
      tick;
      checks++;
      if (sub_en !== 1'b1 || sub_i !== ei || sub_j !== ej) begin
         errors++; $display("FAIL norm_issue[%0d] sub_en=%b sub_i=%h sub_j=%h expected 1/%h/%h", idx, sub_en, sub_i, sub_j, ei, ej);
      end
      for (int c = 0; c < nwait; c++) begin
         tick;
         checks++;
         if (sub_en !== 1'b0 || rsp_valid !== '0 || sub_i !== ei || sub_j !== ej) begin
            errors++; $display("FAIL norm_wait[%0d] sub_en=%b rsp_valid=%b sub_i=%h sub_j=%h expected 0/0/%h/%h", idx, sub_en, rsp_valid, sub_i, sub_j, ei, ej);
         end
      end
      sub_out = res;
      sub_done = 1'b1;
      tick;
      sub_done = 1'b0;
      checks++;
      if (rsp_valid !== exp || rsp_data !== res || rsp_neg !== eneg || rsp_err !== 1'b0 || gnt !== exp) begin
         errors++; $display("FAIL norm_resp[%0d] rsp_valid=%b data=%h neg=%b err=%b gnt=%b expected %b/%h/%b/0/%b",
                            idx, rsp_valid, rsp_data, rsp_neg, rsp_err, gnt, exp, res, eneg, exp);
      end
      req[idx] = 1'b0;
      tick;
      checks++;
      if (rsp_valid !== '0 || gnt !== '0 || busy !== 1'b0) begin
         errors++; $display("FAIL norm_after[%0d] rsp_valid=%b gnt=%b busy=%b expected 0/0/0", idx, rsp_valid, gnt, busy);
      end
   endtask

   task automatic test_bypass;
      logic [W-1:0] av [3] = '{32'h0000_0A52, 32'h0000_0014, 32'h0000_0000};
      logic [W-1:0] bv [3] = '{32'h0000_0A52, 32'h0000_0000, 32'h0000_0014};
      logic [W-1:0] rv [3] = '{32'h0000_0000, 32'h0000_0014, 32'h0000_0014};
      logic         nv [3] = '{1'b0, 1'b0, 1'b1};
      for (int v = 0; v < 3; v++) begin
         a_flat[1*W +: W] = av[v];
         b_flat[1*W +: W] = bv[v];
         req[1] = 1'b1;
         tick;
         checks++;
         if (gnt !== 4'b0010 || sub_en !== 1'b0 || rsp_valid !== '0) begin
            errors++; $display("FAIL byp_grant[%0d] gnt=%b sub_en=%b rsp_valid=%b expected 0010/0/0", v, gnt, sub_en, rsp_valid);
         end
         tick;
         checks++;
         if (rsp_valid !== 4'b0010 || rsp_data !== rv[v] || rsp_neg !== nv[v] || rsp_err !== 1'b0 || sub_en !== 1'b0) begin
            errors++; $display("FAIL byp_resp[%0d] rsp_valid=%b data=%h neg=%b err=%b sub_en=%b expected 0010/%h/%b/0/0",
                               v, rsp_valid, rsp_data, rsp_neg, rsp_err, sub_en, rv[v], nv[v]);
         end
         req[1] = 1'b0;
         tick;
      end
   endtask

   task automatic test_ignore_done;
      sub_out = 32'h0000_0055;
      sub_done = 1'b1;
      tick;
      sub_done = 1'b0;
      tick;
      checks++;
      if (busy !== 1'b0 || rsp_valid !== '0 || sub_en !== 1'b0) begin
         errors++; $display("FAIL stray_done busy=%b rsp_valid=%b sub_en=%b expected 0/0/0", busy, rsp_valid, sub_en);
      end
   endtask

   task automatic test_timeout;
      int n = 0, first_low = 0, lows = 0, ens = 0;
      a_flat[3*W +: W] = 32'h0000_0014;
      b_flat[3*W +: W] = 32'h0000_0005;
      req[3] = 1'b1;
      while (rsp_valid === '0 && n < 1100) begin
         tick;
         n++;
         if (sub_rst_n === 1'b0) begin
            lows++;
            if (first_low == 0) first_low = n;
         end
         if (sub_en === 1'b1) ens++;
      end
      checks++;
      if (n != TIMEOUT + 5) begin errors++; $display("FAIL to_latency got %0d expected %0d", n, TIMEOUT + 5); end
      checks++;
      if (first_low != TIMEOUT + 3 || lows != 2) begin
         errors++; $display("FAIL to_sub_rst first_low=%0d lows=%0d expected %0d/2", first_low, lows, TIMEOUT + 3);
      end
      checks++;
      if (ens != 1) begin errors++; $display("FAIL to_sub_en pulses got %0d expected 1", ens); end
      checks++;
      if (rsp_valid !== 4'b1000 || rsp_err !== 1'b1 || rsp_data !== '0 || rsp_neg !== 1'b0 || sub_rst_n !== 1'b1) begin
         errors++; $display("FAIL to_resp rsp_valid=%b err=%b data=%h neg=%b sub_rst_n=%b expected 1000/1/0/0/1",
                            rsp_valid, rsp_err, rsp_data, rsp_neg, sub_rst_n);
      end
      req[3] = 1'b0;
      tick;
      checks++;
      if (busy !== 1'b0 || gnt !== '0) begin errors++; $display("FAIL to_after busy=%b gnt=%b expected 0/0", busy, gnt); end
   endtask

   task automatic test_reset_mid;
      a_flat[1*W +: W] = 32'h0000_0014;
      b_flat[1*W +: W] = 32'h0000_0005;
      req[1] = 1'b1;
      tick;
      tick;
      tick;
      checks++;
      if (busy !== 1'b1 || gnt !== 4'b0010) begin errors++; $display("FAIL mid_prewait busy=%b gnt=%b expected 1/0010", busy, gnt); end
      rst = 1'b0;
      #1;
      checks++;
      if (gnt !== '0 || busy !== 1'b0 || rsp_valid !== '0 || sub_en !== 1'b0 || sub_rst_n !== 1'b0) begin
         errors++; $display("FAIL mid_reset gnt=%b busy=%b rsp_valid=%b sub_en=%b sub_rst_n=%b expected 0/0/0/0/0",
                            gnt, busy, rsp_valid, sub_en, sub_rst_n);
      end
      req = 4'b1000;
      a_flat[3*W +: W] = 32'h0000_0A52;
      b_flat[3*W +: W] = 32'h0000_0A52;
      sub_done = 1'b1;
      tick;
      sub_done = 1'b0;
      tick;
      checks++;
      if (rsp_valid !== '0 || busy !== 1'b0 || gnt !== '0) begin
         errors++; $display("FAIL mid_held rsp_valid=%b busy=%b gnt=%b expected 0/0/0", rsp_valid, busy, gnt);
      end
      rst = 1'b1;
      tick;
      checks++;
      if (gnt !== 4'b1000) begin errors++; $display("FAIL mid_regrant gnt got %b expected 1000", gnt); end
      tick;
      checks++;
      if (rsp_valid !== 4'b1000 || rsp_data !== '0 || rsp_err !== 1'b0) begin
         errors++; $display("FAIL mid_resp rsp_valid=%b data=%h err=%b expected 1000/0/0", rsp_valid, rsp_data, rsp_err);
      end
      req = '0;
      tick;
   endtask

   initial begin
      test_reset;
      test_round_robin;
      test_normal(0, 32'h0000_0014, 32'h0000_0005, 32'h0000_0014, 32'h0000_0005, 1'b0, 32'h0000_000A, 1);
      test_normal(2, 32'h0000_0005, 32'h0000_0014, 32'h0000_0014, 32'h0000_0005, 1'b1, 32'h0000_000A, 3);
      test_bypass;
      test_ignore_done;
      test_timeout;
      test_normal(0, 32'h0000_0014, 32'h0000_0005, 32'h0000_0014, 32'h0000_0005, 1'b0, 32'h0000_000A, 2);
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
